if_id_latch: RTL and testbench
==============================

# if_id_latch

Pipeline register between instruction fetch and decode. It captures the fetched instruction, current PC, PC+2 and fetch error when the instruction memory reports `Done`. It inserts a NOP bubble when fetch is stalled or the pipeline is flushed, and holds its contents while decode stalls on a hazard. A one-entry skid buffer absorbs an instruction that completes fetch during a decode stall; a back-pressure output then freezes the fetch PC.

## Interface
- No parameters. NOP encoding is fixed at 16'h0800; HALT is 16'h0000 and is never injected.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fetch_done` input 1: instruction memory `Done`; the fetch inputs are valid this cycle.
- `fetch_stall` input 1: instruction memory `Stall`; informational only (a cycle without `fetch_done` is a bubble).
- `instr_in` input 16: fetched instruction.
- `currPC_in` input 16: address of `instr_in`.
- `pcPlus2_in` input 16: `currPC_in` + 2.
- `err_in` input 1: fetch error flag.
- `hold` input 1: decode hazard stall; freeze the decode-side register.
- `flush` input 1: redirect (branch/jump/siic/rti); discard everything.
- `instr_out` output 16: instruction presented to decode.
- `currPC_out` output 16: PC of `instr_out`.
- `pcPlus2_out` output 16: PC+2 of `instr_out`.
- `err_out` output 1: error flag of `instr_out`.
- `valid_out` output 1: `instr_out` is a real instruction, not a bubble.
- `fetch_hold` output 1: fetch must not advance its PC and must re-present the same address.
- `bubble_cnt` output 16: saturating count of bubble cycles (performance counter).

## Operation
- State machine with three states:
  - EMPTY: out register holds a bubble, `valid_out`=0.
  - FULL: out register valid, skid empty.
  - FULL_SKID: out register valid, skid valid.
- A bubble is `instr_out`=16'h0800, both PC outputs = 0, `err_out`=0, `valid_out`=0.
- "Load" copies `instr_in`, `currPC_in`, `pcPlus2_in` and `err_in` into the out register and sets `valid_out`=1.
- Priority order: `rst` > `flush` > `hold` > normal.
- `flush`: out register takes a bubble, skid is cleared, state goes to EMPTY. This applies in every state and regardless of `hold` or `fetch_done`.
- EMPTY:
  - `hold` is ignored, since a bubble cannot carry a hazard.
  - With `fetch_done`: load, go to FULL.
  - Otherwise: stay EMPTY.
- FULL with `hold`=0:
  - With `fetch_done`: load, stay FULL.
  - Otherwise: out register takes a bubble, go to EMPTY.
- FULL with `hold`=1:
  - Out register is unchanged.
  - With `fetch_done`: skid captures all four fetch inputs, go to FULL_SKID.
  - Otherwise: stay FULL.
- FULL_SKID:
  - `fetch_done` is ignored; fetch re-presents the same PC because `fetch_hold`=1.
  - With `hold`=1: stay FULL_SKID.
  - With `hold`=0: out register takes the skid contents, skid is cleared, go to FULL.
- `fetch_hold` = (state == FULL_SKID). It is decoded from the registered state, so there is no combinational path from any input.
- `bubble_cnt`: increments by 1 on every edge where `valid_out`=0 before the edge. It saturates at 16'hFFFF and clears only on `rst`.
- `fetch_stall` does not change any state.

## Timing
- Reset values:
  - State EMPTY.
  - `instr_out`=16'h0800; `currPC_out`, `pcPlus2_out` = 16'h0000.
  - `err_out`, `valid_out`, `fetch_hold` = 0.
  - `bubble_cnt`=0; skid cleared.
- Latency: 1 cycle from `fetch_done` to the outputs (FULL/EMPTY paths). The skid path adds 1 cycle after `hold` falls.
- A bubble appears the cycle after a non-`fetch_done` cycle while unheld.
- `flush` takes effect at the next edge. `valid_out`=0 is guaranteed the cycle after `flush`, even if `fetch_done` and `hold` are also high.
- Reset asserted mid-operation (any state, skid full) restores all reset values at the next edge. `rst` overrides `flush`.
- Ordering: no instruction is ever lost or duplicated while `flush`=0. Instructions leave in fetch order.

## Test plan
- Reset then streaming: `fetch_done`=1 each cycle with PCs 0,2,4 (`instr_in` 16'hC001, 16'hC002, 16'hC003) -> after one cycle `valid_out`=1 and the outputs track the inputs one cycle late; `bubble_cnt`=1 (the reset cycle only).
- Memory stall: `fetch_done`=0 for 3 cycles while FULL, `fetch_stall`=1 -> `instr_out`=16'h0800, `valid_out`=0 for 3 cycles; `bubble_cnt` increases by 3.
- Skid: while FULL at PC 4, set `hold`=1 and deliver PC 6 with `fetch_done` -> `fetch_hold`=1 the next cycle and the outputs stay PC 4. Drop `hold` -> the outputs show PC 6 and `fetch_hold`=0.
- Flush in FULL_SKID with `hold`=1 and `fetch_done`=1 -> the next cycle `valid_out`=0, `instr_out`=16'h0800, `fetch_hold`=0; the skid contents are never emitted.
- Error propagation: `err_in`=1 with `fetch_done` at PC 16'h0010 -> `err_out`=1 with `currPC_out`=16'h0010. The following bubble has `err_out`=0.
- Mid-operation reset in FULL_SKID -> all reset values the next cycle; `bubble_cnt` counting from 16'hFFFF stays saturated until reset, then 0.

Source files
------------

// File: rtl/if_id_latch.sv
// if_id_latch: fetch -> decode pipeline register with a one-entry skid buffer.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   EMPTY     | out register holds a NOP bubble, valid_out = 0
//   FULL      | out register valid, skid empty
//   FULL_SKID | out register valid, skid holds the next instruction
//
// The skid catches the one instruction that completes fetch in the same
// cycle decode stalls. fetch_hold is decoded from the registered state,
// so it has no combinational path from any input.
module if_id_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_done,
    input  logic        fetch_stall,
    input  logic [15:0] instr_in,
    input  logic [15:0] currPC_in,
    input  logic [15:0] pcPlus2_in,
    input  logic        err_in,
    input  logic        hold,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] currPC_out,
    output logic [15:0] pcPlus2_out,
    output logic        err_out,
    output logic        valid_out,
    output logic        fetch_hold,
    output logic [15:0] bubble_cnt
);

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_SKID = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus2;
        logic        err;
        logic        valid;
    } entry_t;

    localparam entry_t BUBBLE = '{instr: NOP_INSTR, pc: 16'h0000,
                                  pc_plus2: 16'h0000, err: 1'b0, valid: 1'b0};

    state_e      state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    entry_t      fetch_ent;

    // fetch_stall is informational only; a cycle without fetch_done is a bubble.
    logic unused_fetch_stall;
    assign unused_fetch_stall = fetch_stall;

    assign fetch_ent = '{instr: instr_in, pc: currPC_in, pc_plus2: pcPlus2_in,
                         err: err_in, valid: 1'b1};

    // Next-state and datapath selection; flush beats hold beats normal flow.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            out_d   = BUBBLE;
            skid_d  = BUBBLE;
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    // A bubble cannot carry a hazard, so hold is ignored here.
                    if (fetch_done) begin
                        out_d   = fetch_ent;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (hold) begin
                        if (fetch_done) begin
                            skid_d  = fetch_ent;
                            state_d = FULL_SKID;
                        end
                    end else if (fetch_done) begin
                        out_d = fetch_ent;
                    end else begin
                        out_d   = BUBBLE;
                        state_d = EMPTY;
                    end
                end
                FULL_SKID: begin
                    // Fetch is frozen by fetch_hold, so fetch_done is ignored.
                    if (!hold) begin
                        out_d   = skid_q;
                        skid_d  = BUBBLE;
                        state_d = FULL;
                    end
                end
                default: begin
                    out_d   = BUBBLE;
                    skid_d  = BUBBLE;
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Saturating count of cycles that presented a bubble to decode.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_q.valid && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_q        <= BUBBLE;
            skid_q       <= BUBBLE;
            bubble_cnt_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign instr_out   = out_q.instr;
    assign currPC_out  = out_q.pc;
    assign pcPlus2_out = out_q.pc_plus2;
    assign err_out     = out_q.err;
    assign valid_out   = out_q.valid;
    assign fetch_hold  = (state_q == FULL_SKID);
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_if_id_latch.sv
// Bench for if_id_latch: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_if_id_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_done = 1'b0;
    logic        fetch_stall = 1'b0;
    logic [15:0] instr_in = 16'h0;
    logic [15:0] currPC_in = 16'h0;
    logic [15:0] pcPlus2_in = 16'h0;
    logic        err_in = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out, currPC_out, pcPlus2_out, bubble_cnt;
    logic        err_out, valid_out, fetch_hold;

    int n_checks = 0;
    int n_errors = 0;

    if_id_latch dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_done (fetch_done),
        .fetch_stall(fetch_stall),
        .instr_in   (instr_in),
        .currPC_in  (currPC_in),
        .pcPlus2_in (pcPlus2_in),
        .err_in     (err_in),
        .hold       (hold),
        .flush      (flush),
        .instr_out  (instr_out),
        .currPC_out (currPC_out),
        .pcPlus2_out(pcPlus2_out),
        .err_out    (err_out),
        .valid_out  (valid_out),
        .fetch_hold (fetch_hold),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        err;
        logic        valid;
    } ent_t;

    localparam ent_t M_BUBBLE = '{instr: 16'h0800, pc: 16'h0, pc2: 16'h0, err: 1'b0, valid: 1'b0};

    // Reference model: what decode sees, plus a queue of at most one waiting instruction.
    ent_t        m_out = M_BUBBLE;
    ent_t        m_wait[$];
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        ent_t fe;
        fe = '{instr: instr_in, pc: currPC_in, pc2: pcPlus2_in, err: err_in, valid: 1'b1};
        if (rst) begin
            m_out = M_BUBBLE;
            m_wait.delete();
            m_cnt = 0;
        end else begin
            if (!m_out.valid) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (flush) begin
                m_out = M_BUBBLE;
                m_wait.delete();
            end else if (m_out.valid && hold) begin
                if (fetch_done && m_wait.size() == 0) m_wait.push_back(fe);
            end else if (m_wait.size() != 0) begin
                m_out = m_wait.pop_front();
            end else if (fetch_done) begin
                m_out = fe;
            end else begin
                m_out = M_BUBBLE;
            end
        end
    endtask

    task automatic compare_all();
        chk("instr_out",   {16'h0, instr_out},   {16'h0, m_out.instr});
        chk("currPC_out",  {16'h0, currPC_out},  {16'h0, m_out.pc});
        chk("pcPlus2_out", {16'h0, pcPlus2_out}, {16'h0, m_out.pc2});
        chk("err_out",     {31'h0, err_out},     {31'h0, m_out.err});
        chk("valid_out",   {31'h0, valid_out},   {31'h0, m_out.valid});
        chk("fetch_hold",  {31'h0, fetch_hold},  {31'h0, (m_wait.size() != 0)});
        chk("bubble_cnt",  {16'h0, bubble_cnt},  m_cnt);
    endtask

    // One clock: apply inputs, let the edge happen, update model, check #1 later.
    task automatic cyc(input logic r, input logic fd, input logic h, input logic fl,
                       input logic [15:0] ins, input logic [15:0] pc, input logic e,
                       input logic do_chk);
        rst        = r;
        fetch_done = fd;
        hold       = h;
        flush      = fl;
        instr_in   = ins;
        currPC_in  = pc;
        pcPlus2_in = pc + 16'd2;
        err_in     = e;
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) compare_all();
    endtask

    initial begin
        #2;
        // Reset
        cyc(1, 0, 0, 0, 16'h1234, 16'h0, 0, 1);
        chk("rst_instr", {16'h0, instr_out}, 32'h0800);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_cnt",   {16'h0, bubble_cnt}, 32'h0);

        // Streaming
        cyc(0, 1, 0, 0, 16'hC001, 16'h0, 0, 1);
        chk("stream_v0",  {31'h0, valid_out}, 32'h1);
        chk("stream_pc0", {16'h0, currPC_out}, 32'h0);
        cyc(0, 1, 0, 0, 16'hC002, 16'h2, 0, 1);
        cyc(0, 1, 0, 0, 16'hC003, 16'h4, 0, 1);
        chk("stream_instr", {16'h0, instr_out}, 32'hC003);
        chk("stream_pc2",   {16'h0, pcPlus2_out}, 32'h6);
        chk("stream_cnt",   {16'h0, bubble_cnt}, 32'h1);

        // Memory stall: three bubble cycles
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 16'hDEAD, 16'h6, 0, 1);
            chk("stall_valid", {31'h0, valid_out}, 32'h0);
            chk("stall_instr", {16'h0, instr_out}, 32'h0800);
        end
        fetch_stall = 1'b0;
        cyc(0, 1, 0, 0, 16'hC003, 16'h4, 0, 1);
        chk("stall_cnt", {16'h0, bubble_cnt}, 32'h4);

        // Skid
        cyc(0, 1, 1, 0, 16'hC004, 16'h6, 0, 1);
        chk("skid_fh",  {31'h0, fetch_hold}, 32'h1);
        chk("skid_pc4", {16'h0, currPC_out}, 32'h4);
        cyc(0, 1, 1, 0, 16'hC004, 16'h6, 0, 1);
        chk("skid_hold_pc4", {16'h0, currPC_out}, 32'h4);
        cyc(0, 1, 0, 0, 16'hC004, 16'h6, 0, 1);
        chk("skid_pc6", {16'h0, currPC_out}, 32'h6);
        chk("skid_fh0", {31'h0, fetch_hold}, 32'h0);

        // Flush in FULL_SKID with hold and fetch_done high
        cyc(0, 1, 0, 0, 16'hC005, 16'h8, 0, 1);
        cyc(0, 1, 1, 0, 16'hC006, 16'hA, 0, 1);
        chk("fl_pre_fh", {31'h0, fetch_hold}, 32'h1);
        cyc(0, 1, 1, 1, 16'hC006, 16'hA, 0, 1);
        chk("fl_valid", {31'h0, valid_out}, 32'h0);
        chk("fl_instr", {16'h0, instr_out}, 32'h0800);
        chk("fl_fh",    {31'h0, fetch_hold}, 32'h0);
        cyc(0, 1, 0, 0, 16'hC007, 16'hC, 0, 1);
        chk("fl_after_pc", {16'h0, currPC_out}, 32'hC);

        // Error propagation
        cyc(0, 1, 0, 0, 16'hC008, 16'h0010, 1, 1);
        chk("err_out", {31'h0, err_out}, 32'h1);
        chk("err_pc",  {16'h0, currPC_out}, 32'h10);
        cyc(0, 0, 0, 0, 16'hC009, 16'h0012, 1, 1);
        chk("err_bubble", {31'h0, err_out}, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, fd, h, fl;
            r  = ($urandom_range(0, 199) == 0);
            fd = ($urandom_range(0, 9) < 7);
            h  = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 19) == 0);
            fetch_stall = ~fd;
            cyc(r, fd, h, fl, 16'($urandom), 16'($urandom) & 16'hFFFE, 1'($urandom), 1);
        end
        fetch_stall = 1'b0;

        // Saturation: idle long enough to pass 16'hFFFF, then mid-op reset in FULL_SKID
        cyc(1, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 65540; i++) cyc(0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        compare_all();
        chk("sat_cnt", {16'h0, bubble_cnt}, 32'hFFFF);
        cyc(0, 1, 0, 0, 16'hC010, 16'h20, 0, 1);
        cyc(0, 1, 1, 0, 16'hC011, 16'h22, 1, 1);
        chk("sat_hold", {16'h0, bubble_cnt}, 32'hFFFF);
        chk("sat_fh",   {31'h0, fetch_hold}, 32'h1);
        cyc(1, 1, 1, 1, 16'hC011, 16'h22, 1, 1);
        chk("mrst_cnt",   {16'h0, bubble_cnt}, 32'h0);
        chk("mrst_fh",    {31'h0, fetch_hold}, 32'h0);
        chk("mrst_valid", {31'h0, valid_out}, 32'h0);
        chk("mrst_instr", {16'h0, instr_out}, 32'h0800);
        chk("mrst_pc",    {16'h0, currPC_out}, 32'h0);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        chk("mrst_skid_gone", {31'h0, valid_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
